// File: rtl/spi_slave_param_pkg.sv
// Shared types and constants for the parametrised SPI slave front end.
package spi_slave_param_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA,
      TX_WAIT,
      TX_SHIFT
   } spi_state_e;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   // Saturating 8-bit increment for the status counters.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/spi_slave_param_shift_reg.sv
// Serial-in / serial-out shifter (MSB first) with parallel load and bit counter.
module spi_shift_reg
   import spi_slave_param_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_clear,
   input  logic                   i_load,
   input  logic [W-1:0]           i_load_data,
   input  logic                   i_shift,
   input  logic                   i_sin,
   output logic [W-1:0]           o_data,
   output logic [$clog2(W+1)-1:0] o_cnt
);

   localparam int unsigned CW = $clog2(W + 1);

   logic [W-1:0]  r_data;
   logic [CW-1:0] r_cnt;

   // Clear only restarts the count; the data word is left for the owner to ignore.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
         r_cnt  <= '0;
      end else if (i_clear) begin
         r_cnt  <= '0;
      end else if (i_load) begin
         r_data <= i_load_data;
         r_cnt  <= '0;
      end else if (i_shift) begin
         r_data <= W'({r_data, i_sin});
         r_cnt  <= r_cnt + CW'(1);
      end
   end

   assign o_data = r_data;
   assign o_cnt  = r_cnt;

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: frames {opcode, payload} into rx_data and returns RAM read data on MISO.
// Optional status counters (abort_cnt, timeout_cnt) are built when SPI_SLAVE_STATUS_EN is defined.
module spi_slave_param
   import spi_slave_param_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned TX_TIMEOUT = 16,
   parameter logic        MISO_IDLE  = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              frame_abort,
   output logic              tx_timeout
`ifdef SPI_SLAVE_STATUS_EN
   ,
   output logic [7:0]        abort_cnt,
   output logic [7:0]        timeout_cnt
`endif
);

   localparam int unsigned RX_W = DATA_W + 2;
   localparam int unsigned RCW  = $clog2(RX_W + 1);
   localparam int unsigned TCW  = $clog2(DATA_W + 1);
   localparam int unsigned TW   = $clog2(TX_TIMEOUT + 1);

   spi_state_e        r_state;
   logic              r_done;
   logic              r_rd_addr_seen;
   logic [TW-1:0]     r_wait_cnt;
   logic              r_miso;
   logic [RX_W-1:0]   r_rx_data;
   logic              r_rx_valid;
   logic              r_frame_abort;
   logic              r_tx_timeout;

   logic              w_in_rx;
   logic              w_rx_shift;
   logic              w_rx_clear;
   logic              w_rx_last;
   logic [RX_W-1:0]   w_rx_sh;
   logic [RX_W-1:0]   w_rx_word;
   logic [RCW-1:0]    w_rx_cnt;
   logic              w_tx_load;
   logic              w_tx_shift;
   logic              w_tx_clear;
   logic [DATA_W-1:0] w_tx_sh;
   logic [TCW-1:0]    w_tx_cnt;
   logic              w_tx_unused;

   assign w_in_rx    = (r_state == WRITE) || (r_state == READ_ADD) || (r_state == READ_DATA);
   assign w_rx_shift = w_in_rx && !r_done && !SS_n;
   assign w_rx_clear = SS_n || (r_state == IDLE);
   assign w_rx_last  = (w_rx_cnt == RCW'(RX_W - 1));
   assign w_rx_word  = RX_W'({w_rx_sh, MOSI});

   assign w_tx_load  = (r_state == TX_WAIT) && !r_done && !SS_n && tx_valid;
   assign w_tx_shift = (r_state == TX_SHIFT) && !r_done && !SS_n;
   assign w_tx_clear = SS_n || (r_state == IDLE);
   assign w_tx_unused = ^w_tx_sh;

   spi_shift_reg #(.W(RX_W)) u_rx_shift (
      .clk         (clk),
      .rst         (rst),
      .i_clear     (w_rx_clear),
      .i_load      (1'b0),
      .i_load_data ('0),
      .i_shift     (w_rx_shift),
      .i_sin       (MOSI),
      .o_data      (w_rx_sh),
      .o_cnt       (w_rx_cnt)
   );

   // The MSB goes straight to MISO on the latch edge, so the shifter holds the remaining bits.
   spi_shift_reg #(.W(DATA_W)) u_tx_shift (
      .clk         (clk),
      .rst         (rst),
      .i_clear     (w_tx_clear),
      .i_load      (w_tx_load),
      .i_load_data (DATA_W'({tx_data, 1'b0})),
      .i_shift     (w_tx_shift),
      .i_sin       (1'b0),
      .o_data      (w_tx_sh),
      .o_cnt       (w_tx_cnt)
   );

   // r_done marks a frame that has finished its work; SS_n rising before that is an abort.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_done         <= 1'b0;
         r_rd_addr_seen <= 1'b0;
         r_wait_cnt     <= '0;
         r_miso         <= MISO_IDLE;
         r_rx_data      <= '0;
         r_rx_valid     <= 1'b0;
         r_frame_abort  <= 1'b0;
         r_tx_timeout   <= 1'b0;
      end else begin
         r_rx_valid    <= 1'b0;
         r_frame_abort <= 1'b0;
         r_tx_timeout  <= 1'b0;
         if ((r_state != IDLE) && SS_n) begin
            r_state       <= IDLE;
            r_done        <= 1'b0;
            r_wait_cnt    <= '0;
            r_miso        <= MISO_IDLE;
            r_frame_abort <= !r_done;
         end else begin
            case (r_state)
               IDLE: begin
                  r_done     <= 1'b0;
                  r_wait_cnt <= '0;
                  r_miso     <= MISO_IDLE;
                  if (!SS_n) r_state <= CHK_CMD;
               end
               CHK_CMD: begin
                  if (!MOSI)               r_state <= WRITE;
                  else if (!r_rd_addr_seen) r_state <= READ_ADD;
                  else                     r_state <= READ_DATA;
               end
               WRITE, READ_ADD, READ_DATA: begin
                  if (!r_done && w_rx_last) begin
                     r_rx_data  <= w_rx_word;
                     r_rx_valid <= 1'b1;
                     if (r_state == READ_DATA) begin
                        r_rd_addr_seen <= 1'b0;
                        r_wait_cnt     <= '0;
                        r_state        <= TX_WAIT;
                     end else begin
                        r_done <= 1'b1;
                        if (r_state == READ_ADD) r_rd_addr_seen <= 1'b1;
                     end
                  end
               end
               TX_WAIT: begin
                  if (!r_done) begin
                     if (tx_valid) begin
                        r_state <= TX_SHIFT;
                        r_miso  <= tx_data[DATA_W-1];
                        r_done  <= (DATA_W == 1);
                     end else if (r_wait_cnt == TW'(TX_TIMEOUT - 1)) begin
                        r_tx_timeout <= 1'b1;
                        r_done       <= 1'b1;
                        r_miso       <= MISO_IDLE;
                     end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                     end
                  end
               end
               TX_SHIFT: begin
                  if (!r_done) begin
                     r_miso <= w_tx_sh[DATA_W-1];
                     if (w_tx_cnt == TCW'(DATA_W - 2)) r_done <= 1'b1;
                  end else begin
                     r_miso <= MISO_IDLE;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign MISO        = r_miso;
   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign frame_abort = r_frame_abort;
   assign tx_timeout  = r_tx_timeout;

`ifdef SPI_SLAVE_STATUS_EN
   logic [7:0] r_abort_cnt;
   logic [7:0] r_timeout_cnt;

   // Counters follow the registered strobes, one cycle behind them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_abort_cnt   <= '0;
         r_timeout_cnt <= '0;
      end else begin
         if (r_frame_abort) r_abort_cnt   <= sat_inc8(r_abort_cnt);
         if (r_tx_timeout)  r_timeout_cnt <= sat_inc8(r_timeout_cnt);
      end
   end

   assign abort_cnt   = r_abort_cnt;
   assign timeout_cnt = r_timeout_cnt;
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// Randomised frame-level bench for spi_slave_param (8-bit and 16-bit payload instances).
module tb_spi_slave_param;
   import spi_slave_param_pkg::*;

   localparam int unsigned DW  = 8;
   localparam int unsigned FW  = DW + 2;
   localparam int unsigned TO  = 16;
   localparam int unsigned D16 = 16;
   localparam int unsigned F16 = D16 + 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, ss_n, mosi, miso, rx_valid, tx_valid, frame_abort, tx_timeout;
   logic [FW-1:0] rx_data;
   logic [DW-1:0] tx_data;
   logic           ss16, mosi16, miso16, rxv16, txv16, ab16, to16;
   logic [F16-1:0] rx16;
   logic [D16-1:0] tx16;
`ifdef SPI_SLAVE_STATUS_EN
   logic [7:0] st_ab, st_to, st_ab16, st_to16;
`endif

   spi_slave_param #(.DATA_W(DW), .TX_TIMEOUT(TO), .MISO_IDLE(1'b0)) dut8 (
      .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .MISO(miso),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
      .frame_abort(frame_abort), .tx_timeout(tx_timeout)
`ifdef SPI_SLAVE_STATUS_EN
      , .abort_cnt(st_ab), .timeout_cnt(st_to)
`endif
   );

   spi_slave_param #(.DATA_W(D16), .TX_TIMEOUT(TO), .MISO_IDLE(1'b0)) dut16 (
      .clk(clk), .rst(rst), .SS_n(ss16), .MOSI(mosi16), .MISO(miso16),
      .rx_data(rx16), .rx_valid(rxv16), .tx_data(tx16), .tx_valid(txv16),
      .frame_abort(ab16), .tx_timeout(to16)
`ifdef SPI_SLAVE_STATUS_EN
      , .abort_cnt(st_ab16), .timeout_cnt(st_to16)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: frame-level protocol state
   logic          mdl_rd_seen = 1'b0;
   logic [FW-1:0] mdl_rx = '0;
   int            mdl_ab = 0;
   int            mdl_to = 0;

   // Observations accumulated per frame
   int             g_edge, g_vcnt, g_vedge, g_ab, g_to, g_toedge, g_mhi;
   logic [FW-1:0]  g_cap;
   int             g16_vcnt, g16_vedge, g16_ab;
   logic [F16-1:0] g16_cap;

   task automatic clear_mon();
      g_edge = 0; g_vcnt = 0; g_vedge = 0; g_ab = 0; g_to = 0; g_toedge = 0; g_mhi = 0;
      g_cap = '0; g16_vcnt = 0; g16_vedge = 0; g16_ab = 0; g16_cap = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      g_edge++;
      if (rx_valid) begin g_vcnt++; g_vedge = g_edge; g_cap = rx_data; end
      if (frame_abort) g_ab++;
      if (tx_timeout) begin g_to++; g_toedge = g_edge; end
      if (miso !== 1'b0) g_mhi++;
      if (rxv16) begin g16_vcnt++; g16_vedge = g_edge; g16_cap = rx16; end
      if (ab16) g16_ab++;
   endtask

   task automatic start_frame(input logic cmd);
      clear_mon();
      ss_n = 1'b0; mosi = 1'($urandom); step();
      mosi = cmd; step();
   endtask

   task automatic send_bits(input logic [FW-1:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         mosi = w[FW-1-i];
         step();
      end
   endtask

   task automatic end_frame();
      ss_n = 1'b1; mosi = 1'b0;
      step(); step();
   endtask

   task automatic test_reset();
      rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
      ss16 = 1'b1; mosi16 = 1'b0; txv16 = 1'b0; tx16 = '0;
      clear_mon();
      step(); step();
      n_checks++; if (miso !== 1'b0) begin n_errors++; $display("FAIL reset_miso got %b exp 0", miso); end
      n_checks++; if (rx_data !== '0) begin n_errors++; $display("FAIL reset_rx_data got %h exp 0", rx_data); end
      n_checks++; if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
      n_checks++; if (frame_abort !== 1'b0 || tx_timeout !== 1'b0) begin n_errors++; $display("FAIL reset_strobes got %b%b exp 00", frame_abort, tx_timeout); end
      n_checks++; if (rx16 !== '0) begin n_errors++; $display("FAIL reset_rx16 got %h exp 0", rx16); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_write();
      for (int it = 0; it < 5; it++) begin
         logic [FW-1:0] w;
         w = (it == 0) ? FW'(10'h0A5) : FW'($urandom);
         start_frame(1'b0);
         send_bits(w, FW);
         n_checks++; if (g_vedge !== 2 + FW) begin n_errors++; $display("FAIL write_latency got %0d exp %0d", g_vedge, 2 + FW); end
         n_checks++; if (g_cap !== w) begin n_errors++; $display("FAIL write_data got %h exp %h", g_cap, w); end
         repeat (3) step();
         end_frame();
         mdl_rx = w;
         n_checks++; if (g_vcnt !== 1) begin n_errors++; $display("FAIL write_valid_count got %0d exp 1", g_vcnt); end
         n_checks++; if (g_ab !== 0 || g_mhi !== 0) begin n_errors++; $display("FAIL write_quiet got abort=%0d miso_hi=%0d exp 0/0", g_ab, g_mhi); end
         n_checks++; if (rx_data !== mdl_rx) begin n_errors++; $display("FAIL write_hold got %h exp %h", rx_data, mdl_rx); end
      end
   endtask

   task automatic test_abort();
      logic [FW-1:0] w;
      // Abort after five payload bits of a write
      w = FW'($urandom);
      start_frame(1'b0); send_bits(w, 5); end_frame();
      mdl_ab++;
      n_checks++; if (g_ab !== 1 || g_vcnt !== 0) begin n_errors++; $display("FAIL abort_mid got abort=%0d valid=%0d exp 1/0", g_ab, g_vcnt); end
      n_checks++; if (rx_data !== mdl_rx) begin n_errors++; $display("FAIL abort_mid_hold got %h exp %h", rx_data, mdl_rx); end
      // SS_n rises on the edge that samples the final bit
      w = FW'($urandom);
      start_frame(1'b0); send_bits(w, FW - 1);
      mosi = w[0]; ss_n = 1'b1; step(); step();
      mdl_ab++;
      n_checks++; if (g_ab !== 1 || g_vcnt !== 0) begin n_errors++; $display("FAIL abort_last_bit got abort=%0d valid=%0d exp 1/0", g_ab, g_vcnt); end
      n_checks++; if (rx_data !== mdl_rx) begin n_errors++; $display("FAIL abort_last_hold got %h exp %h", rx_data, mdl_rx); end
      // Abort while waiting for read data
      if (!mdl_rd_seen) begin
         w = FW'($urandom);
         start_frame(1'b1); send_bits(w, FW); end_frame();
         mdl_rd_seen = 1'b1; mdl_rx = w;
      end
      w = FW'($urandom);
      start_frame(1'b1); send_bits(w, FW); repeat (3) step(); end_frame();
      mdl_rd_seen = 1'b0; mdl_rx = w; mdl_ab++;
      n_checks++; if (g_ab !== 1 || g_vcnt !== 1) begin n_errors++; $display("FAIL abort_tx_wait got abort=%0d valid=%0d exp 1/1", g_ab, g_vcnt); end
      // Aborted read-address frame leaves rd_addr_seen clear: next read frame is an address again
      start_frame(1'b1); send_bits(FW'($urandom), 4); end_frame();
      mdl_ab++;
      n_checks++; if (g_ab !== 1 || g_vcnt !== 0) begin n_errors++; $display("FAIL abort_rd_addr got abort=%0d valid=%0d exp 1/0", g_ab, g_vcnt); end
      w = FW'($urandom);
      start_frame(1'b1); send_bits(w, FW); repeat (TO + 4) step(); end_frame();
      mdl_rd_seen = 1'b1; mdl_rx = w;
      n_checks++; if (g_to !== 0 || g_cap !== w || g_ab !== 0) begin n_errors++; $display("FAIL abort_rd_seen_kept got timeout=%0d data=%h abort=%0d exp 0/%h/0", g_to, g_cap, g_ab, w); end
`ifdef SPI_SLAVE_STATUS_EN
      n_checks++; if (st_ab !== 8'(mdl_ab)) begin n_errors++; $display("FAIL status_abort_cnt got %0d exp %0d", st_ab, mdl_ab); end
`endif
   endtask

   task automatic test_read();
      for (int it = 0; it < 5; it++) begin
         logic [FW-1:0] aw, dw;
         logic [DW-1:0] d, got;
         int            w;
         aw = (it == 0) ? FW'(10'b1000001111) : FW'($urandom);
         dw = (it == 0) ? FW'(10'b1100000000) : FW'($urandom);
         d  = (it == 0) ? DW'(8'h96) : DW'($urandom);
         w  = (it == 0) ? 2 : int'($urandom_range(0, 12));
         got = '0;
         if (!mdl_rd_seen) begin
            start_frame(1'b1); send_bits(aw, FW);
            repeat (TO + 4) step();
            n_checks++; if (g_vcnt !== 1 || g_cap !== aw || g_to !== 0) begin n_errors++; $display("FAIL read_addr got valid=%0d data=%h timeout=%0d exp 1/%h/0", g_vcnt, g_cap, g_to, aw); end
            end_frame();
            mdl_rd_seen = 1'b1; mdl_rx = aw;
         end
         if ($urandom_range(0, 1) == 1) begin
            logic [FW-1:0] ww;
            ww = FW'($urandom);
            start_frame(1'b0); send_bits(ww, FW); end_frame();
            mdl_rx = ww;
            n_checks++; if (g_cap !== ww) begin n_errors++; $display("FAIL read_interleaved_write got %h exp %h", g_cap, ww); end
         end
         start_frame(1'b1); send_bits(dw, FW);
         mdl_rd_seen = 1'b0; mdl_rx = dw;
         n_checks++; if (g_vcnt !== 1 || g_vedge !== 2 + FW || g_cap !== dw) begin n_errors++; $display("FAIL read_data_rx got valid=%0d edge=%0d data=%h exp 1/%0d/%h", g_vcnt, g_vedge, g_cap, 2 + FW, dw); end
         repeat (w) step();
         n_checks++; if (g_mhi !== 0) begin n_errors++; $display("FAIL read_wait_miso got %0d high cycles exp 0", g_mhi); end
         tx_data = d; tx_valid = 1'b1; step();
         tx_valid = 1'b0; tx_data = DW'($urandom);
         got[DW-1] = miso;
         for (int b = DW - 2; b >= 0; b--) begin
            step();
            got[b] = miso;
         end
         n_checks++; if (got !== d) begin n_errors++; $display("FAIL read_miso_bits got %h exp %h", got, d); end
         step();
         n_checks++; if (miso !== 1'b0) begin n_errors++; $display("FAIL read_miso_idle got %b exp 0", miso); end
         end_frame();
         n_checks++; if (g_ab !== 0 || g_to !== 0 || g_vcnt !== 1) begin n_errors++; $display("FAIL read_clean_end got abort=%0d timeout=%0d valid=%0d exp 0/0/1", g_ab, g_to, g_vcnt); end
      end
   endtask

   task automatic test_timeout();
      logic [FW-1:0] w;
      if (!mdl_rd_seen) begin
         w = FW'($urandom);
         start_frame(1'b1); send_bits(w, FW); end_frame();
         mdl_rd_seen = 1'b1; mdl_rx = w;
      end
      w = FW'($urandom);
      start_frame(1'b1); send_bits(w, FW);
      tx_valid = 1'b0;
      repeat (TO + 8) step();
      mdl_rd_seen = 1'b0; mdl_rx = w; mdl_to++;
      n_checks++; if (g_to !== 1) begin n_errors++; $display("FAIL timeout_count got %0d exp 1", g_to); end
      n_checks++; if (g_toedge !== 2 + FW + TO) begin n_errors++; $display("FAIL timeout_edge got %0d exp %0d", g_toedge, 2 + FW + TO); end
      n_checks++; if (g_mhi !== 0) begin n_errors++; $display("FAIL timeout_miso got %0d high cycles exp 0", g_mhi); end
      end_frame();
      n_checks++; if (rx_data !== mdl_rx) begin n_errors++; $display("FAIL timeout_rx_hold got %h exp %h", rx_data, mdl_rx); end
`ifdef SPI_SLAVE_STATUS_EN
      n_checks++; if (st_to !== 8'(mdl_to)) begin n_errors++; $display("FAIL status_timeout_cnt got %0d exp %0d", st_to, mdl_to); end
`endif
   endtask

   task automatic test_mid_reset();
      logic [FW-1:0] w;
      w = FW'($urandom);
      start_frame(1'b0); send_bits(w, 5);
      mosi = w[FW-6]; rst = 1'b1; step();
      ss_n = 1'b1;
      mdl_rx = '0; mdl_rd_seen = 1'b0; mdl_ab = 0; mdl_to = 0;
      n_checks++; if (rx_data !== '0 || rx_valid !== 1'b0 || miso !== 1'b0) begin n_errors++; $display("FAIL midrst_outputs got data=%h valid=%b miso=%b exp 0/0/0", rx_data, rx_valid, miso); end
      n_checks++; if (frame_abort !== 1'b0 || tx_timeout !== 1'b0) begin n_errors++; $display("FAIL midrst_strobes got %b%b exp 00", frame_abort, tx_timeout); end
      rst = 1'b0; step();
      n_checks++; if (frame_abort !== 1'b0) begin n_errors++; $display("FAIL midrst_no_abort got %b exp 0", frame_abort); end
      w = FW'($urandom);
      start_frame(1'b0); send_bits(w, FW); end_frame();
      mdl_rx = w;
      n_checks++; if (g_vcnt !== 1 || g_cap !== w || rx_data !== mdl_rx) begin n_errors++; $display("FAIL midrst_next_frame got valid=%0d data=%h exp 1/%h", g_vcnt, rx_data, w); end
   endtask

   task automatic test_width16();
      for (int it = 0; it < 3; it++) begin
         logic [F16-1:0] w;
         w = (it == 0) ? {OP_WR_DATA, 16'hBEEF} : F16'($urandom);
         clear_mon();
         ss16 = 1'b0; step();
         mosi16 = 1'b0; step();
         for (int b = F16 - 1; b >= 0; b--) begin
            mosi16 = w[b];
            step();
         end
         n_checks++; if (g16_vcnt !== 1 || g16_vedge !== 2 + F16) begin n_errors++; $display("FAIL w16_latency got valid=%0d edge=%0d exp 1/%0d", g16_vcnt, g16_vedge, 2 + F16); end
         n_checks++; if (g16_cap !== w) begin n_errors++; $display("FAIL w16_data got %h exp %h", g16_cap, w); end
         ss16 = 1'b1; step(); step();
         n_checks++; if (g16_ab !== 0 || rx16 !== w) begin n_errors++; $display("FAIL w16_hold got abort=%0d data=%h exp 0/%h", g16_ab, rx16, w); end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_abort();
      test_read();
      test_timeout();
      test_mid_reset();
      test_width16();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
